ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 30 +++
 rtl/ex_muldiv_div_step.sv | 27 ++
 rtl/ex_muldiv.sv | 160 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and helpers for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } mdOp_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDiv  = 2'b10,
        StDone = 2'b11
    } mdState_e;

    // Quotient reported when the divisor is zero.
    localparam logic [31:0] DivZeroQuo = 32'hFFFF_FFFF;

    function automatic logic isSignedOp(input mdOp_e op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

    // Magnitude of a value, treated as two's complement only when isSigned is set.
    function automatic logic [31:0] absVal(input logic [31:0] v, input logic isSigned);
        return (isSigned && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module ex_muldiv_div_step (
    input  logic [31:0] remIn,
    input  logic [31:0] quoIn,
    input  logic [31:0] divisor,
    output logic [31:0] remOut,
    output logic [31:0] quoOut
);

    logic [32:0] shifted;
    logic [32:0] diff;

    // Trial subtraction; bit 32 of diff set means the divisor did not fit.
    always_comb begin
        shifted = {remIn, quoIn[31]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[32]) begin
            remOut = diff[31:0];
            quoOut = {quoIn[30:0], 1'b1};
        end else begin
            remOut = shifted[31:0];
            quoOut = {quoIn[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU finish in one cycle after the start edge; DIV/DIVU run 32
// restoring steps on magnitudes and fix the signs on the final step.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        startE,
    input  logic [1:0]  mdOpE,
    input  logic [31:0] srcAE,
    input  logic [31:0] srcBE,
    input  logic        flushE,
    input  logic        hiWe,
    input  logic        loWe,
    input  logic [31:0] wdata,
    output logic        stallReq,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdState_e    stateQ, stateD;
    logic [4:0]  cntQ, cntD;
    mdOp_e       opQ, opD;
    logic [31:0] rawAQ, rawAD;
    logic [31:0] rawBQ, rawBD;
    logic [31:0] remQ, remD;
    logic [31:0] quoQ, quoD;
    logic [31:0] divisorQ, divisorD;
    logic [31:0] hiQ, hiD;
    logic [31:0] loQ, loD;

    logic [31:0] stepRem, stepQuo;
    logic [31:0] quoFix, remFix;
    logic [63:0] mulA, mulB, product;
    logic        signedOp;
    logic        startOk;
    logic        startSigned;

    ex_muldiv_div_step divStep (
        .remIn   (remQ),
        .quoIn   (quoQ),
        .divisor (divisorQ),
        .remOut  (stepRem),
        .quoOut  (stepQuo)
    );

    // Datapath for the latched operation: product and sign-corrected division result.
    always_comb begin
        signedOp = isSignedOp(opQ);
        mulA     = {{32{signedOp & rawAQ[31]}}, rawAQ};
        mulB     = {{32{signedOp & rawBQ[31]}}, rawBQ};
        product  = mulA * mulB;
        quoFix   = (signedOp && (rawAQ[31] ^ rawBQ[31])) ? (~stepQuo + 32'd1) : stepQuo;
        remFix   = (signedOp && rawAQ[31]) ? (~stepRem + 32'd1) : stepRem;
    end

    // Next-state logic for FSM, counter, operands and HI/LO.
    always_comb begin
        stateD      = stateQ;
        cntD        = cntQ;
        opD         = opQ;
        rawAD       = rawAQ;
        rawBD       = rawBQ;
        remD        = remQ;
        quoD        = quoQ;
        divisorD    = divisorQ;
        hiD         = hiQ;
        loD         = loQ;
        startOk     = startE & ~flushE;
        startSigned = isSignedOp(mdOp_e'(mdOpE));

        unique case (stateQ)
            StIdle: begin
                if (startOk) begin
                    opD      = mdOp_e'(mdOpE);
                    rawAD    = srcAE;
                    rawBD    = srcBE;
                    cntD     = 5'd0;
                    remD     = 32'd0;
                    quoD     = absVal(srcAE, startSigned);
                    divisorD = absVal(srcBE, startSigned);
                    stateD   = mdOpE[1] ? StDiv : StMul;
                end else if (!startE) begin
                    if (hiWe) hiD = wdata;
                    if (loWe) loD = wdata;
                end
            end
            StMul: begin
                hiD    = product[63:32];
                loD    = product[31:0];
                stateD = StDone;
            end
            StDiv: begin
                if (divisorQ == 32'd0) begin
                    hiD    = rawAQ;
                    loD    = DivZeroQuo;
                    stateD = StDone;
                end else begin
                    remD = stepRem;
                    quoD = stepQuo;
                    cntD = cntQ + 5'd1;
                    if (cntQ == 5'd31) begin
                        hiD    = remFix;
                        loD    = quoFix;
                        stateD = StDone;
                    end
                end
            end
            StDone: begin
                stateD = StIdle;
            end
        endcase

        // A flush abandons whatever is in flight and never touches HI/LO.
        if (flushE) begin
            stateD = StIdle;
            hiD    = hiQ;
            loD    = loQ;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= StIdle;
            cntQ     <= 5'd0;
            opQ      <= OpMult;
            rawAQ    <= 32'd0;
            rawBQ    <= 32'd0;
            remQ     <= 32'd0;
            quoQ     <= 32'd0;
            divisorQ <= 32'd0;
            hiQ      <= 32'd0;
            loQ      <= 32'd0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            opQ      <= opD;
            rawAQ    <= rawAD;
            rawBQ    <= rawBD;
            remQ     <= remD;
            quoQ     <= quoD;
            divisorQ <= divisorD;
            hiQ      <= hiD;
            loQ      <= loD;
        end
    end

    // Outputs; stall covers the issuing cycle so the instruction holds in EX.
    always_comb begin
        done     = (stateQ == StDone);
        stallReq = (stateQ == StMul) || (stateQ == StDiv) ||
                   ((stateQ == StIdle) && startE && !flushE);
        hi       = hiQ;
        lo       = loQ;
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv with a result scoreboard.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        startE;
    logic [1:0]  mdOpE;
    logic [31:0] srcAE, srcBE;
    logic        flushE;
    logic        hiWe, loWe;
    logic [31:0] wdata;
    logic        stallReq, done;
    logic [31:0] hi, lo;

    int nCmp = 0;
    int nErr = 0;
    logic [63:0] sbQ[$];
    logic [63:0] cur;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    ex_muldiv dut (
        .clk      (clk),
        .rst      (rst),
        .startE   (startE),
        .mdOpE    (mdOpE),
        .srcAE    (srcAE),
        .srcBE    (srcBE),
        .flushE   (flushE),
        .hiWe     (hiWe),
        .loWe     (loWe),
        .wdata    (wdata),
        .stallReq (stallReq),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nCmp++;
        assert (obs === expv) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference result {hi, lo} from native arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb2, sp;
        longint unsigned ua, ub, up;
        int qa, qb, q, r;
        case (op)
            MULT: begin
                sa = longint'($signed(a));
                sb2 = longint'($signed(b));
                sp = sa * sb2;
                return 64'(sp);
            end
            MULTU: begin
                ua = 64'(a);
                ub = 64'(b);
                up = ua * ub;
                return up;
            end
            DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qa = $signed(a);
                qb = $signed(b);
                q = qa / qb;
                r = qa % qb;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue one op, track latency and stall cycles, compare result from scoreboard.
    // pokeAt > 0 drives a spurious MULT start on that busy cycle.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int expLat, input int pokeAt, input string tag);
        int cyc;
        int stalls;
        logic [63:0] expv;
        sbQ.push_back(model(op, a, b));
        @(negedge clk);
        startE = 1'b1; mdOpE = op; srcAE = a; srcBE = b;
        #1;
        stalls = stallReq ? 1 : 0;
        @(negedge clk);
        startE = 1'b0; srcAE = $urandom; srcBE = $urandom;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (stallReq) stalls++;
            @(negedge clk);
            cyc++;
            if (cyc == pokeAt) begin
                startE = 1'b1; mdOpE = MULT; srcAE = 32'd7; srcBE = 32'd7;
            end else begin
                startE = 1'b0;
            end
            #1;
        end
        startE = 1'b0;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_lat"}, 64'(cyc), 64'(expLat));
        check({tag, "_stall"}, 64'(stalls), 64'(expLat));
        expv = sbQ.pop_front();
        check({tag, "_hilo"}, {hi, lo}, expv);
        cur = expv;
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int cnt;
        logic [1:0] rop;
        logic [31:0] ra, rb;

        rst = 1'b1; startE = 1'b0; mdOpE = MULT; srcAE = '0; srcBE = '0;
        flushE = 1'b0; hiWe = 1'b0; loWe = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_ctl", {62'd0, done, stallReq}, 64'd0);

        // MTHI / MTLO
        @(negedge clk);
        hiWe = 1'b1; loWe = 1'b1; wdata = 32'h1111_2222;
        @(negedge clk);
        hiWe = 1'b0; wdata = 32'h3333_4444;
        @(negedge clk);
        loWe = 1'b0;
        check("mthilo", {hi, lo}, {32'h1111_2222, 32'h3333_4444});
        cur = {hi, lo};

        // Directed results with fixed expectations
        check("model_mult", model(MULT, 32'hFFFF_FFFE, 32'd3), {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        runOp(MULT,  32'hFFFF_FFFE, 32'd3, 2, 0, "mult");
        check("mult_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        runOp(MULTU, 32'hFFFF_FFFE, 32'd3, 2, 0, "multu");
        check("multu_const", {hi, lo}, {32'h0000_0002, 32'hFFFF_FFFA});
        runOp(DIV, 32'hFFFF_FFF9, 32'd2, 33, 0, "div");
        check("div_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        runOp(DIVU, 32'd100, 32'd7, 33, 0, "divu");
        check("divu_const", {hi, lo}, {32'd2, 32'd14});
        runOp(DIVU, 32'd5, 32'd0, 2, 0, "divu0");
        check("divu0_const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        runOp(DIV, 32'hFFFF_FFFB, 32'd0, 2, 0, "div0");
        runOp(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 0, "divovf");
        check("divovf_const", {hi, lo}, {32'd0, 32'h8000_0000});
        runOp(DIV, 32'd17, 32'hFFFF_FFFB, 33, 0, "divneg");

        // Random mix
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'($urandom_range(1, 20)) : $urandom;
            runOp(rop, ra, rb, (rop[1] && rb != 32'd0) ? 33 : 2, 0, "rnd");
        end

        // Start ignored while busy
        runOp(DIVU, 32'd1000, 32'd9, 33, 5, "busypoke");

        // Flush at iteration 10
        @(negedge clk);
        startE = 1'b1; mdOpE = DIV; srcAE = 32'd1000; srcBE = 32'd3;
        @(negedge clk);
        startE = 1'b0;
        repeat (9) @(negedge clk);
        flushE = 1'b1;
        @(negedge clk);
        flushE = 1'b0;
        #1;
        check("flush_idle", {62'd0, done, stallReq}, 64'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("flush_nodone", 64'(cnt), 64'd0);
        check("flush_hilo", {hi, lo}, cur);
        runOp(MULT, 32'd12345, 32'hFFFF_FF00, 2, 0, "postflush");

        // Flush together with start: nothing begins
        @(negedge clk);
        startE = 1'b1; flushE = 1'b1; mdOpE = MULT; srcAE = 32'd9; srcBE = 32'd9;
        #1;
        check("flushstart_stall", 64'(stallReq), 64'd0);
        @(negedge clk);
        startE = 1'b0; flushE = 1'b0;
        @(negedge clk);
        check("flushstart_done", 64'(done), 64'd0);
        check("flushstart_hilo", {hi, lo}, cur);

        // hiWe/loWe alongside startE are ignored
        @(negedge clk);
        startE = 1'b1; mdOpE = MULTU; srcAE = 32'd2; srcBE = 32'd3;
        hiWe = 1'b1; loWe = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        startE = 1'b0; hiWe = 1'b0; loWe = 1'b0;
        check("wewithstart_hilo", {hi, lo}, cur);
        @(negedge clk);
        check("wewithstart_done", 64'(done), 64'd1);
        check("wewithstart_res", {hi, lo}, {32'd0, 32'd6});
        @(negedge clk);

        // Reset at iteration 20
        @(negedge clk);
        startE = 1'b1; mdOpE = DIVU; srcAE = 32'hFFFF_0000; srcBE = 32'd13;
        @(negedge clk);
        startE = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_ctl", {62'd0, done, stallReq}, 64'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("midrst_nodone", 64'(cnt), 64'd0);
        runOp(DIVU, 32'd99, 32'd10, 33, 0, "postrst");

        check("sb_empty", 64'(sbQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
